// File: rtl/bnn_loader_pkg.sv
// rtl/bnn_loader_pkg.sv - default dimensions and stream fill state for the BNN parameter loader
package bnn_loader_pkg;

    localparam int IMG_W_D     = 28;
    localparam int IMG_H_D     = 28;
    localparam int N_KERNELS_D = 8;
    localparam int K_D         = 3;

    typedef enum logic {
        FILL_LOAD = 1'b0,
        FILL_FULL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/stream_fill.sv
// rtl/stream_fill.sv - one serial stream: beat counter, LOAD/FULL fsm and storage vector
module stream_fill
    import bnn_loader_pkg::*;
#(
    parameter int DEPTH = 784,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic [LANES-1:0] data,
    output logic [DEPTH-1:0] buffer,
    output logic             full,
    output logic             overrun_hit
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - LANES);
    localparam logic [CW-1:0] STEP = CW'(LANES);

    fill_state_t   state;
    fill_state_t   state_next;
    logic [CW-1:0] cnt;
    logic          accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = FILL_LOAD;
        end else if (state == FILL_LOAD && valid && cnt == LAST) begin
            state_next = FILL_FULL;
        end
    end

    // start outranks any beat in the same cycle, so it suppresses both write and overrun
    always_comb begin
        accept      = (state == FILL_LOAD) && valid && !start;
        overrun_hit = (state == FILL_FULL) && valid && !start;
        full        = (state == FILL_FULL);
    end

    // cnt stays a multiple of LANES and parks on LAST once the stream is full
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            buffer <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (accept) begin
            buffer[cnt +: LANES] <= data;
            if (cnt != LAST) begin
                cnt <= cnt + STEP;
            end
        end
    end

endmodule

// File: rtl/bnn_param_loader.sv
// rtl/bnn_param_loader.sv - fills the BNN image and binary weight buffers from two serial streams
module bnn_param_loader
    import bnn_loader_pkg::*;
#(
    parameter int IMG_W     = IMG_W_D,
    parameter int IMG_H     = IMG_H_D,
    parameter int N_KERNELS = N_KERNELS_D,
    parameter int K         = K_D,
    parameter int P_LANES   = 1,
    parameter int W_LANES   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     p_valid,
    input  logic [P_LANES-1:0]       d_in_p,
    input  logic                     w_valid,
    input  logic [W_LANES-1:0]       d_in_w,
    output logic [IMG_H*IMG_W-1:0]   pixels,
    output logic [N_KERNELS*K*K-1:0] weights,
    output logic                     pix_full,
    output logic                     wt_full,
    output logic                     load_done,
    output logic                     overrun
);

    localparam int P_DEPTH = IMG_H * IMG_W;
    localparam int W_DEPTH = N_KERNELS * K * K;

    if (P_DEPTH % P_LANES != 0) begin : g_bad_p_lanes
        $error("IMG_W*IMG_H must be divisible by P_LANES");
    end
    if (W_DEPTH % W_LANES != 0) begin : g_bad_w_lanes
        $error("N_KERNELS*K*K must be divisible by W_LANES");
    end

    logic p_hit;
    logic w_hit;

    stream_fill #(.DEPTH(P_DEPTH), .LANES(P_LANES)) u_pix (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .valid       (p_valid),
        .data        (d_in_p),
        .buffer      (pixels),
        .full        (pix_full),
        .overrun_hit (p_hit)
    );

    stream_fill #(.DEPTH(W_DEPTH), .LANES(W_LANES)) u_wt (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .valid       (w_valid),
        .data        (d_in_w),
        .buffer      (weights),
        .full        (wt_full),
        .overrun_hit (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset || start) begin
            overrun <= 1'b0;
        end else if (p_hit || w_hit) begin
            overrun <= 1'b1;
        end
    end

    assign load_done = pix_full & wt_full;

endmodule
